// File: rtl/scratchpad_mm2s_stream.sv
// Read-side DMA sequencer: issues scratchpad word reads, absorbs the fixed read
// latency and streams the returned words out over AXI-Stream with tlast.
module scratchpad_mm2s_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 16,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PTR_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  dma_rd_en,
  output logic [PTR_WIDTH-1:0]  dma_read_pointer,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [PTR_WIDTH-1:0]  len_q;
  logic [PTR_WIDTH-1:0]  issue_cnt;
  logic [PTR_WIDTH-1:0]  beat_cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [RD_LATENCY-1:0] pipe_last;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         in_flight;
  logic                  credit;
  logic                  issue_last;
  logic                  push;
  logic                  pop;
  logic                  final_beat;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CW'(pipe_vld[i]);
    end
  end

  // Credit counts every word either in the read pipeline or buffered, so a
  // granted read always has a FIFO slot waiting when its data returns.
  assign credit           = (in_flight + fifo_count) < CW'(FIFO_DEPTH);
  assign dma_rd_en        = (state == ISSUE) && credit;
  assign dma_read_pointer = issue_cnt;
  assign issue_last       = dma_rd_en && (issue_cnt == len_q - PTR_WIDTH'(1));

  assign push          = pipe_vld[RD_LATENCY-1];
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign final_beat    = pop && (state == DRAIN) && (beat_cnt == len_q - PTR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      len_q      <= '0;
      issue_cnt  <= '0;
      beat_cnt   <= '0;
      pipe_vld   <= '0;
      pipe_last  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              len_q     <= length;
              issue_cnt <= '0;
              beat_cnt  <= '0;
              state     <= ISSUE;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (dma_rd_en) begin
            issue_cnt <= issue_cnt + PTR_WIDTH'(1);
            if (issue_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (final_beat) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        beat_cnt <= beat_cnt + PTR_WIDTH'(1);
        rd_ptr   <= rd_ptr + AW'(1);
      end

      pipe_vld[0]  <= dma_rd_en;
      pipe_last[0] <= issue_last;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end

      if (push) begin
        fifo_data[wr_ptr] <= dma_rd_data;
        fifo_last[wr_ptr] <= pipe_last[RD_LATENCY-1];
        wr_ptr            <= wr_ptr + AW'(1);
      end

      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      if (push && !pop) begin
        assert (fifo_count != CW'(FIFO_DEPTH));
      end
    end
  end

endmodule
